multicycle_ctrl_p: RTL

MULTICYCLE_CTRL_P -- requirements
Module: multicycle_ctrl_p

---
 rtl/multicycle_ctrl_p.sv | 353 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_p.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_p
//
// Control unit for a classic multicycle datapath. A 4-bit state register walks
// every instruction through FETCH -> DECODE -> execute -> write-back and drives
// the datapath strobes and mux selects as combinational functions of the
// current state and the instruction register.
//
// Parameters
//   INSTR_W      instruction width
//   ALUOP_W      ALU op / subcode width; opcode is the top ALUOP_W+2 bits of
//                the instruction, its top 2 bits are the class
//   MEM_TIMEOUT  maximum wait cycles per memory access (>= 2)
//   CNT_W        retired-instruction counter width
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   instr_in       instruction register contents, stable from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   stall          freeze request: state and wait counter hold, write strobes
//                  and status pulses are suppressed
//   PCWrite .. RegDst    1-bit datapath strobes / selects
//   PCSource, ALUSrcB    2-bit mux selects
//   ALUOp          ALU operation
//   state          current state code
//   halted         level, high while in HALT
//   illegal        1-cycle pulse on an undefined class-11 opcode
//   bus_err        1-cycle pulse when a memory access times out
//   retire         1-cycle pulse when an instruction completes
//   instr_count    retired instructions, wraps to 0
//
// Status pulses are combinational: they are high during the last cycle of the
// state that makes the corresponding transition, i.e. in the cycle whose
// rising edge carries the controller back to FETCH. instr_count is updated on
// that same edge.
// -----------------------------------------------------------------------------
module multicycle_ctrl_p #(
    parameter int INSTR_W     = 32,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mem_ready,
    input  logic               stall,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_count
);

    // -------------------------------------------------------------------------
    // State encoding (codes 12..14 are unused and recover to FETCH)
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_I_EXEC   = 4'd3,
        S_R_EXEC   = 4'd4,
        S_BRANCH   = 4'd5,
        S_JUMP     = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_HALT     = 4'd11,
        S_IDLE     = 4'd15
    } state_e;

    localparam int OPW    = ALUOP_W + 2;
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    // Value of the wait counter during the last permitted waiting cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Class-11 subcodes with the MSB set select the extended group.
    localparam logic [ALUOP_W-1:0] SUB_EXT  = ALUOP_W'(1) << (ALUOP_W - 1);
    localparam logic [ALUOP_W-1:0] SUB_LI   = SUB_EXT | ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] SUB_LUI  = SUB_EXT | ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] SUB_LD_A = SUB_EXT | ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] SUB_ST_A = SUB_EXT | ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] SUB_LD_B = SUB_EXT | ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] SUB_ST_B = SUB_EXT | ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] SUB_ONES = '1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e             state_q,       state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,    wait_cnt_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    // -------------------------------------------------------------------------
    // Instruction field extraction
    // -------------------------------------------------------------------------
    logic [OPW-1:0]     opcode;
    logic [1:0]         op_class;
    logic [ALUOP_W-1:0] subcode;
    logic               unused_instr_bits;

    assign opcode   = instr_in[INSTR_W-1 -: OPW];
    assign op_class = opcode[OPW-1 -: 2];
    assign subcode  = opcode[ALUOP_W-1:0];

    // Operand fields below the opcode belong to the datapath, not to control.
    assign unused_instr_bits = ^instr_in[INSTR_W-OPW-1:0];

    // -------------------------------------------------------------------------
    // Opcode decode: target state leaving DECODE plus NOP / illegal flags
    // -------------------------------------------------------------------------
    state_e dec_next;
    logic   dec_nop;
    logic   dec_illegal;
    logic   is_store;

    always_comb begin
        dec_next    = S_FETCH;
        dec_nop     = 1'b0;
        dec_illegal = 1'b0;

        if (opcode == '0) begin
            dec_nop = 1'b1;
        end else begin
            case (op_class)
                2'b00:   dec_next = (subcode == SUB_ONES) ? S_HALT : S_JUMP;
                2'b01:   dec_next = S_R_EXEC;
                2'b10:   dec_next = S_BRANCH;
                default: begin
                    if (!subcode[ALUOP_W-1]) begin
                        dec_next = S_I_EXEC;
                    end else begin
                        case (subcode)
                            SUB_LI, SUB_LUI:     dec_next = S_I_EXEC;
                            SUB_LD_A, SUB_LD_B,
                            SUB_ST_A, SUB_ST_B:  dec_next = S_MEM_ADDR;
                            default:             dec_illegal = 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    // instr_in is stable from DECODE onward, so MEM_ADDR re-decodes the
    // load/store direction instead of carrying it in a flop.
    assign is_store = (subcode == SUB_ST_A) || (subcode == SUB_ST_B);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    logic wait_expired;

    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    always_comb begin
        // NOTE: every variable written here gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        wait_cnt_d  = '0;          // any cycle that is not a waiting cycle clears it
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = '0;
        halted      = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;   // PC + 4
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;   // re-entry restarts the wait count
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                ALUSrcB = 2'b11;   // branch target precompute
                state_d = dec_next;
                illegal = dec_illegal;
                retire  = dec_nop;
            end

            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = is_store ? S_MEM_WR : S_MEM_RD;
            end

            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = subcode;
                state_d = S_ALU_WB;
            end

            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = subcode;
                state_d = S_ALU_WB;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b00;
                ALUOp       = subcode;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (wait_expired) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    // An abandoned store must not look like a write to memory.
                    MemWrite = 1'b0;
                    bus_err  = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_ALU_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
                RegDst   = (op_class == 2'b01);   // R-type writes rd
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                RegDst   = 1'b0;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;   // only reset leaves HALT
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Stall freezes progress: mem_ready is ignored, nothing is written and
        // no status pulse fires; read-side selects keep their values.
        if (stall) begin
            state_d     = state_q;
            wait_cnt_d  = wait_cnt_q;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            illegal     = 1'b0;
            bus_err     = 1'b0;
            retire      = 1'b0;
        end

        instr_count_d = instr_count_q + CNT_W'(retire);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule
